imem_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the instruction ROM: owns the fetch PC, drives the ROM address, tracks the ROM's 1-cycle registered read.

---
 rtl/imem_fetch_pkg.sv | 17 +
 rtl/fetch_skid_fifo.sv | 60 ++++++
 rtl/imem_fetch_ctrl.sv | 94 +++++++++
 tb/tb_imem_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_pkg.sv
// Shared widths and defaults for the instruction fetch sequencer.
// Imported by the skid FIFO and the fetch controller.
package imem_fetch_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_RESET_PC   = 0;
  localparam int DEF_FIFO_DEPTH = 2;

  localparam int FETCH_ENTRY_W =
    DEF_DATA_WIDTH + DEF_ADDR_WIDTH;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small synchronous FIFO of {pc, word} entries between ROM and decode.
// Flush wins over push; a pop alongside a flush is simply absorbed.
module fetch_skid_fifo
  import imem_fetch_pkg::*;
#(
  parameter int W     = FETCH_ENTRY_W,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= nxt(wr_q);
      end
      if (pop_i) begin
        rd_q <= nxt(rd_q);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, tracks the ROM's registered read
// and hands words to decode through a skid FIFO with redirect flush.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RESET_PC   = DEF_RESET_PC,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam int EW = DATA_WIDTH + ADDR_WIDTH;
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  inflight_q;
  logic                  kill_q;
  logic [CW-1:0]         count;
  logic [EW-1:0]         head;
  logic [CW:0]           occ;
  logic                  pop;
  logic                  push;
  logic                  issue;

  assign pop  = inst_valid & inst_ready;
  assign push = inflight_q & ~kill_q;

  // Occupancy counts the word already in flight so the FIFO never overflows.
  assign occ = {1'b0, count}
             + (CW + 1)'(inflight_q)
             - (CW + 1)'(pop);

  assign issue = !halt && !redirect_valid && (occ < DEPTH_C);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    unique case (1'b1)
      redirect_valid: fetch_pc_d = redirect_pc;
      issue:          fetch_pc_d = fetch_pc_q + 1'b1;
      default:        fetch_pc_d = fetch_pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= ADDR_WIDTH'(RESET_PC);
      pc_q       <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      kill_q     <= redirect_valid;
      if (issue) begin
        pc_q <= fetch_pc_q;
      end
    end
  end

  fetch_skid_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .wdata_i ({pc_q, imem_data}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .rdata_o (head),
    .count_o (count)
  );

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (count != '0);
  assign inst_pc    = head[EW-1:DATA_WIDTH];
  assign inst_data  = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a queue-level reference model.
// ROM model returns 0xA000_0000 + address one cycle after the address.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [9:0]  inst_pc;

  int checks = 0;
  int errors = 0;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    imem_data <= 32'hA000_0000 + {22'd0, imem_addr};

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue of PCs, one in-flight slot.
  int unsigned mq[$];
  bit          m_inf;
  int unsigned m_ipc;
  int unsigned m_fpc;

  always @(posedge clk or negedge rst) begin
    bit m_pop;
    bit m_iss;
    int occ;
    if (!rst) begin
      mq.delete();
      m_inf = 0;
      m_ipc = 0;
      m_fpc = 0;
    end else begin
      m_pop = (mq.size() > 0) && inst_ready;
      occ   = mq.size() + int'(m_inf) - int'(m_pop);
      m_iss = !halt && !redirect_valid && (occ < 2);
      if (m_pop) void'(mq.pop_front());
      if (redirect_valid) mq.delete();
      else if (m_inf) mq.push_back(m_ipc);
      m_ipc = m_fpc;
      if (redirect_valid) m_fpc = redirect_pc;
      else if (m_iss) m_fpc = (m_fpc + 1) % 1024;
      m_inf = m_iss;
    end
  end

  int unsigned acc[$];
  int unsigned acc_dat[$];

  always @(negedge clk) begin
    #1;
    chk("valid", inst_valid, mq.size() > 0);
    chk("addr", imem_addr, m_fpc);
    if (mq.size() > 0) begin
      chk("pc", inst_pc, mq[0]);
      chk("data", inst_data, 32'hA000_0000 + mq[0]);
    end
    if (rst && inst_valid && inst_ready) begin
      acc.push_back(inst_pc);
      acc_dat.push_back(inst_data);
    end
  end

  function automatic int unsigned accv(input int i);
    return (i < acc.size()) ? acc[i] : 32'hFFFF;
  endfunction

  task automatic chk_seq(input string name, input int min_n);
    bit ok;
    ok = acc.size() >= min_n;
    for (int i = 1; i < acc.size(); i++)
      if (acc[i] != (acc[i-1] + 1) % 1024) ok = 0;
    chk(name, ok, 1);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int n5;

  initial begin
    rst            = 1'b0;
    inst_ready     = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #12;
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_addr", imem_addr, 0);

    // 1: start-up latency and back-to-back stream
    tick();
    acc.delete();
    rst = 1'b1;
    tick(); #2;
    chk("t1_valid_c1", inst_valid, 0);
    tick(); #2;
    chk("t1_valid_c2", inst_valid, 1);
    chk("t1_pc_c2", inst_pc, 0);
    chk("t1_data_c2", inst_data, 32'hA000_0000);
    repeat (4) tick();
    #2;
    chk("t1_pc0", accv(0), 0);
    chk("t1_pc1", accv(1), 1);
    chk("t1_pc2", accv(2), 2);
    chk("t1_pc3", accv(3), 3);

    // 2: decode stalls for 5 cycles
    tick();
    acc.delete();
    tick();
    inst_ready = 1'b0;
    repeat (5) tick();
    inst_ready = 1'b1;
    repeat (6) tick();
    #2;
    chk_seq("t2_seq", 6);

    // 3: redirect with a full pipe
    tick();
    inst_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h100;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    acc.delete();
    acc_dat.delete();
    #2;
    chk("t3_valid_low", inst_valid, 0);
    repeat (5) tick();
    #2;
    chk("t3_pc0", accv(0), 10'h100);
    chk("t3_data0", (acc_dat.size() > 0) ? acc_dat[0] : 0,
        32'hA000_0100);
    chk("t3_pc1", accv(1), 10'h101);

    // 4: redirect to the top of the address space
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3FF;
    tick();
    redirect_valid = 1'b0;
    acc.delete();
    repeat (6) tick();
    #2;
    chk("t4_pc0", accv(0), 10'h3FF);
    chk("t4_pc1", accv(1), 10'h000);
    chk("t4_pc2", accv(2), 10'h001);

    // 5: halt for 6 cycles
    tick();
    acc.delete();
    halt = 1'b1;
    repeat (5) tick();
    #2;
    n5 = acc.size();
    chk("t5_drained", n5 <= 2 && n5 > 0, 1);
    tick();
    halt = 1'b0;
    repeat (6) tick();
    #2;
    chk("t5_resumed", acc.size() > n5, 1);
    chk_seq("t5_seq", 4);

    // 6: asynchronous reset between edges
    repeat (3) tick();
    #3 rst = 1'b0;
    #1;
    chk("t6_valid", inst_valid, 0);
    chk("t6_pc", inst_pc, 0);
    chk("t6_data", inst_data, 0);
    chk("t6_addr", imem_addr, 0);
    tick();
    #2 rst = 1'b1;
    acc.delete();
    repeat (6) tick();
    #2;
    chk("t6_pc0", accv(0), 0);
    chk("t6_pc1", accv(1), 1);
    chk("t6_pc2", accv(2), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
